// File: rtl/mips_pkg.sv
// Shared MIPS control definitions: opcodes, ALU/mux encodings
// and the multi-cycle controller state type.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] SRCB_RT    = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   typedef enum logic [3:0] {
      RESET     = 4'd0,
      FETCH     = 4'd1,
      DECODE    = 4'd2,
      MEM_ADDR  = 4'd3,
      MEM_READ  = 4'd4,
      MEM_WB    = 4'd5,
      MEM_WRITE = 4'd6,
      R_EXEC    = 4'd7,
      R_WB      = 4'd8,
      BRANCH    = 4'd9,
      JUMP      = 4'd10
   } ctrl_state_t;

endpackage

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main controller: sequences fetch, decode,
// execute, memory and write-back over a shared memory port and ALU.
module mips_multicycle_ctrl
   import mips_pkg::*;
#(
   parameter bit ENABLE_JUMP = 1'b1,
   parameter int STATE_W     = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         opcode,
   input  logic               mem_ready,
   output logic               PCWrite,
   output logic               PCWriteCond,
   output logic               IorD,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               MemtoReg,
   output logic               IRWrite,
   output logic [1:0]         PCSource,
   output logic [1:0]         ALUOp,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic               RegWrite,
   output logic               RegDst,
   output logic               instr_done,
   output logic               illegal_op,
   output logic [STATE_W-1:0] dbg_state
);

   ctrl_state_t state;
   ctrl_state_t nextState;

   always_ff @(posedge clk) begin
      if (rst) state <= RESET;
      else     state <= nextState;
   end

   assign dbg_state = STATE_W'(state);

   always_comb begin
      nextState   = state;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      IRWrite     = 1'b0;
      PCSource    = PCSRC_ALU;
      ALUOp       = ALUOP_ADD;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_RT;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      instr_done  = 1'b0;
      illegal_op  = 1'b0;
      case (state)
         RESET: nextState = FETCH;
         FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = SRCB_FOUR;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
            if (mem_ready) nextState = DECODE;
         end
         DECODE: begin
            ALUSrcB = SRCB_IMMSH;
            case (opcode)
               OP_RTYPE:     nextState = R_EXEC;
               OP_LW, OP_SW: nextState = MEM_ADDR;
               OP_BEQ:       nextState = BRANCH;
               OP_J: begin
                  if (ENABLE_JUMP) begin
                     nextState = JUMP;
                  end else begin
                     nextState  = FETCH;
                     illegal_op = 1'b1;
                     instr_done = 1'b1;
                  end
               end
               default: begin
                  nextState  = FETCH;
                  illegal_op = 1'b1;
                  instr_done = 1'b1;
               end
            endcase
         end
         MEM_ADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
            // IR still holds the opcode, so lw/sw can be told apart here
            nextState = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
         end
         MEM_READ: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            if (mem_ready) nextState = MEM_WB;
         end
         MEM_WB: begin
            RegWrite   = 1'b1;
            MemtoReg   = 1'b1;
            instr_done = 1'b1;
            nextState  = FETCH;
         end
         MEM_WRITE: begin
            MemWrite   = 1'b1;
            IorD       = 1'b1;
            instr_done = mem_ready;
            if (mem_ready) nextState = FETCH;
         end
         R_EXEC: begin
            ALUSrcA   = 1'b1;
            ALUOp     = ALUOP_FUNCT;
            nextState = R_WB;
         end
         R_WB: begin
            RegWrite   = 1'b1;
            RegDst     = 1'b1;
            instr_done = 1'b1;
            nextState  = FETCH;
         end
         BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = ALUOP_SUB;
            PCWriteCond = 1'b1;
            PCSource    = PCSRC_ALUOUT;
            instr_done  = 1'b1;
            nextState   = FETCH;
         end
         JUMP: begin
            PCWrite    = 1'b1;
            PCSource   = PCSRC_JUMP;
            instr_done = 1'b1;
            nextState  = FETCH;
         end
         default: nextState = FETCH;
      endcase
   end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed vector bench for mips_multicycle_ctrl: per-cycle state and
// output table, then per-instruction latency sequences.
module tb_mips_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] opcode = 6'b0;
   logic       mem_ready = 1'b1;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
   logic       IRWrite, ALUSrcA, RegWrite, RegDst, instr_done, illegal_op;
   logic [1:0] PCSource, ALUOp, ALUSrcB;
   logic [3:0] dbg_state;

   mips_multicycle_ctrl #(.ENABLE_JUMP(1'b1), .STATE_W(4)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
      .IRWrite(IRWrite), .PCSource(PCSource), .ALUOp(ALUOp),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
      .RegDst(RegDst), .instr_done(instr_done), .illegal_op(illegal_op),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        r;
      logic [5:0]  op;
      logic        rdy;
      logic [3:0]  st;
      logic [17:0] out;
   } vec_t;

   vec_t vecs[$];
   int   errors = 0;
   int   checks = 0;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BQ = 6'b000100, JJ = 6'b000010, BAD = 6'b111111;

   function automatic logic [17:0] mk(
      bit pcw, bit pcwc, bit iord, bit mr, bit mw, bit m2r, bit irw,
      logic [1:0] pcs, logic [1:0] aop, bit asa, logic [1:0] asb,
      bit rw, bit rd, bit done, bit ill);
      return {pcw, pcwc, iord, mr, mw, m2r, irw, pcs, aop, asa, asb,
              rw, rd, done, ill};
   endfunction

   function automatic logic [17:0] actual();
      return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
              IRWrite, PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite,
              RegDst, instr_done, illegal_op};
   endfunction

   task automatic add(logic r, logic [5:0] op, logic rdy,
                      logic [3:0] st, logic [17:0] o);
      vec_t v;
      v.r = r; v.op = op; v.rdy = rdy; v.st = st; v.out = o;
      vecs.push_back(v);
   endtask

   logic [17:0] oRst, oFetch, oFetchW, oDec, oDecIll, oAddr, oRd, oMwb;
   logic [17:0] oWrW, oWr, oRex, oRwb, oBr, oJmp;

   logic [5:0] latOp[6];
   int         latExp[6];

   initial begin
      oRst    = '0;
      oFetch  = mk(1,0,0,1,0,0,1,2'd0,2'd0,0,2'd1,0,0,0,0);
      oFetchW = mk(0,0,0,1,0,0,0,2'd0,2'd0,0,2'd1,0,0,0,0);
      oDec    = mk(0,0,0,0,0,0,0,2'd0,2'd0,0,2'd3,0,0,0,0);
      oDecIll = mk(0,0,0,0,0,0,0,2'd0,2'd0,0,2'd3,0,0,1,1);
      oAddr   = mk(0,0,0,0,0,0,0,2'd0,2'd0,1,2'd2,0,0,0,0);
      oRd     = mk(0,0,1,1,0,0,0,2'd0,2'd0,0,2'd0,0,0,0,0);
      oMwb    = mk(0,0,0,0,0,1,0,2'd0,2'd0,0,2'd0,1,0,1,0);
      oWrW    = mk(0,0,1,0,1,0,0,2'd0,2'd0,0,2'd0,0,0,0,0);
      oWr     = mk(0,0,1,0,1,0,0,2'd0,2'd0,0,2'd0,0,0,1,0);
      oRex    = mk(0,0,0,0,0,0,0,2'd0,2'd2,1,2'd0,0,0,0,0);
      oRwb    = mk(0,0,0,0,0,0,0,2'd0,2'd0,0,2'd0,1,1,1,0);
      oBr     = mk(0,1,0,0,0,0,0,2'd1,2'd1,1,2'd0,0,0,1,0);
      oJmp    = mk(1,0,0,0,0,0,0,2'd2,2'd0,0,2'd0,0,0,1,0);

      // reset held, then released
      add(1, LW, 1, 4'd0, oRst);
      add(1, LW, 1, 4'd0, oRst);
      add(1, LW, 1, 4'd0, oRst);
      add(0, LW, 1, 4'd0, oRst);
      // lw, ready ignored outside memory states
      add(0, LW, 1, 4'd1, oFetch);
      add(0, LW, 0, 4'd2, oDec);
      add(0, LW, 0, 4'd3, oAddr);
      add(0, LW, 1, 4'd4, oRd);
      add(0, LW, 0, 4'd5, oMwb);
      // sw with two wait cycles
      add(0, SW, 1, 4'd1, oFetch);
      add(0, SW, 1, 4'd2, oDec);
      add(0, SW, 1, 4'd3, oAddr);
      add(0, SW, 0, 4'd6, oWrW);
      add(0, SW, 0, 4'd6, oWrW);
      add(0, SW, 1, 4'd6, oWr);
      // R-type after a fetch wait, then beq
      add(0, RT, 0, 4'd1, oFetchW);
      add(0, RT, 1, 4'd1, oFetch);
      add(0, RT, 1, 4'd2, oDec);
      add(0, RT, 1, 4'd7, oRex);
      add(0, RT, 1, 4'd8, oRwb);
      add(0, BQ, 1, 4'd1, oFetch);
      add(0, BQ, 1, 4'd2, oDec);
      add(0, BQ, 1, 4'd9, oBr);
      // illegal, then jump
      add(0, BAD, 1, 4'd1, oFetch);
      add(0, BAD, 1, 4'd2, oDecIll);
      add(0, JJ, 1, 4'd1, oFetch);
      add(0, JJ, 1, 4'd2, oDec);
      add(0, JJ, 1, 4'd10, oJmp);
      // reset mid read handshake
      add(0, LW, 1, 4'd1, oFetch);
      add(0, LW, 1, 4'd2, oDec);
      add(0, LW, 0, 4'd3, oAddr);
      add(0, LW, 0, 4'd4, oRd);
      add(1, LW, 0, 4'd4, oRd);
      add(0, LW, 1, 4'd0, oRst);

      latOp  = '{LW, SW, RT, BQ, JJ, BAD};
      latExp = '{5, 4, 4, 3, 3, 2};

      @(posedge clk);
      foreach (vecs[i]) begin
         @(negedge clk);
         rst = vecs[i].r;
         opcode = vecs[i].op;
         mem_ready = vecs[i].rdy;
         #1;
         checks++;
         if (dbg_state !== vecs[i].st) begin
            errors++;
            $display("FAIL state[%0d]: got %0d want %0d",
                     i, dbg_state, vecs[i].st);
         end
         checks++;
         if (actual() !== vecs[i].out) begin
            errors++;
            $display("FAIL outputs[%0d]: got %b want %b",
                     i, actual(), vecs[i].out);
         end
      end

      // latency from FETCH entry to instr_done, zero-wait memory
      for (int k = 0; k < 6; k++) begin
         int  n;
         bit  done;
         opcode = latOp[k];
         mem_ready = 1'b1;
         n = 0;
         done = 1'b0;
         while (!done && n < 10) begin
            @(negedge clk);
            #1;
            n++;
            done = instr_done;
         end
         checks++;
         if (!done || n != latExp[k]) begin
            errors++;
            $display("FAIL latency op=%b: got %0d cycles (done=%0d) want %0d",
                     latOp[k], n, done, latExp[k]);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
